// File: rtl/wave_seq_pkg.sv
// Shared definitions for the wave sequencer: step-entry field layout, FSM states, defaults.
// The GAP state exists only when WAVE_SEQ_MUTE_GAP_EN is defined.
package wave_seq_pkg;
  localparam int DEPTH_DEF = 8;
  localparam int DUR_W_DEF = 16;

  localparam int CFG_W     = 32;
  localparam int DDS_LSB   = 0;
  localparam int DDS_W     = 4;
  localparam int WCS_LSB   = 4;
  localparam int MUL_LSB   = 7;
  localparam int CS_W      = 3;
  localparam int CH_STRIDE = 6;
  localparam int N_LSB     = 28;
  localparam int N_W       = 4;
  localparam int DUR_LSB   = 32;

`ifdef WAVE_SEQ_MUTE_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif
endpackage

// File: rtl/wave_seq_if.sv
// Command, table-write and generator-configuration bundle of the wave sequencer.
interface wave_seq_if
  import wave_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DUR_W = DUR_W_DEF
);
  localparam int AW = $clog2(DEPTH);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [CFG_W+DUR_W-1:0] wr_data;
  logic [AW:0]           num_steps;
  logic                  loop;
  logic                  start;
  logic                  stop;

  logic [3:0]            dds_cs;
  logic [2:0]            wave_cs_0, wave_cs_1, wave_cs_2, wave_cs_3;
  logic [2:0]            mul_0, mul_1, mul_2, mul_3;
  logic [3:0]            n;
  logic                  busy;
  logic                  done;
  logic [AW-1:0]         step_idx;

  modport master (
    output wr_en, wr_addr, wr_data, num_steps, loop, start, stop,
    input  dds_cs, wave_cs_0, wave_cs_1, wave_cs_2, wave_cs_3,
           mul_0, mul_1, mul_2, mul_3, n, busy, done, step_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, num_steps, loop, start, stop,
    output dds_cs, wave_cs_0, wave_cs_1, wave_cs_2, wave_cs_3,
           mul_0, mul_1, mul_2, mul_3, n, busy, done, step_idx
  );
endinterface

// File: rtl/wave_seq_table.sv
// Step table: one synchronous write port, one combinational read port, cleared by reset.
module wave_seq_table
  import wave_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int EW    = CFG_W + DUR_W_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [EW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [EW-1:0] rd_data
);
  logic [EW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/wave_sequencer.sv
// Steps a DDS/waveform generator through a table of timed configurations.
// Define WAVE_SEQ_MUTE_GAP_EN to insert one muted GAP cycle at every step transition.
module wave_sequencer
  import wave_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DUR_W = DUR_W_DEF
) (
  input logic       clk,
  input logic       reset,
  wave_seq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = CFG_W + DUR_W;

  state_t           state, state_nxt;
  logic [EW-1:0]    rd_data;
  logic [AW-1:0]    rd_addr, step_idx, idx_nxt, last_idx, after_idx;
  logic [DUR_W-1:0] cnt, rd_dur, load_dur;
  logic [CFG_W-1:0] cfg_q;
  logic             load, mute, done_nxt, done_q, accept_start, final_cyc, at_last;

  function automatic logic [AW-1:0] last_of(input logic [AW:0] ns);
    if (ns == '0) return '0;
    if (int'(ns) > DEPTH) return AW'(DEPTH - 1);
    return AW'(ns - 1'b1);
  endfunction

  wave_seq_table #(.DEPTH(DEPTH), .EW(EW), .AW(AW)) u_table (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign rd_dur    = rd_data[EW-1:DUR_LSB];
  assign load_dur  = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
  assign final_cyc = (cnt == DUR_W'(1));
  assign at_last   = (step_idx == last_idx);
  assign after_idx = at_last ? '0 : step_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    mute         = 1'b0;
    done_nxt     = 1'b0;
    accept_start = 1'b0;
    idx_nxt      = step_idx;
    rd_addr      = after_idx;
    case (state)
      IDLE: begin
        rd_addr = '0;
        if (bus.start && !bus.stop) begin
          accept_start = 1'b1;
          state_nxt    = RUN;
          load         = 1'b1;
          idx_nxt      = '0;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nxt = IDLE;
          mute      = 1'b1;
        end else if (final_cyc) begin
          if (at_last && !bus.loop) begin
            state_nxt = IDLE;
            mute      = 1'b1;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = after_idx;
`ifdef WAVE_SEQ_MUTE_GAP_EN
            state_nxt = GAP;
            mute      = 1'b1;
`else
            load      = 1'b1;
`endif
          end
        end
      end
`ifdef WAVE_SEQ_MUTE_GAP_EN
      // step_idx already points at the entry to load when leaving GAP
      GAP: begin
        rd_addr = step_idx;
        if (bus.stop) begin
          state_nxt = IDLE;
          mute      = 1'b1;
        end else begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q    <= '0;
      cnt      <= '0;
      step_idx <= '0;
      last_idx <= '0;
      done_q   <= 1'b0;
    end else begin
      if (load)      cfg_q <= rd_data[CFG_W-1:0];
      else if (mute) cfg_q[DDS_LSB +: DDS_W] <= '0;
      if (load)                            cnt <= load_dur;
      else if (state == RUN && !final_cyc) cnt <= cnt - 1'b1;
      if (accept_start) last_idx <= last_of(bus.num_steps);
      step_idx <= idx_nxt;
      done_q   <= done_nxt;
    end
  end

  assign bus.dds_cs    = cfg_q[DDS_LSB +: DDS_W];
  assign bus.wave_cs_0 = cfg_q[WCS_LSB                 +: CS_W];
  assign bus.wave_cs_1 = cfg_q[WCS_LSB + CH_STRIDE     +: CS_W];
  assign bus.wave_cs_2 = cfg_q[WCS_LSB + 2 * CH_STRIDE +: CS_W];
  assign bus.wave_cs_3 = cfg_q[WCS_LSB + 3 * CH_STRIDE +: CS_W];
  assign bus.mul_0     = cfg_q[MUL_LSB                 +: CS_W];
  assign bus.mul_1     = cfg_q[MUL_LSB + CH_STRIDE     +: CS_W];
  assign bus.mul_2     = cfg_q[MUL_LSB + 2 * CH_STRIDE +: CS_W];
  assign bus.mul_3     = cfg_q[MUL_LSB + 3 * CH_STRIDE +: CS_W];
  assign bus.n         = cfg_q[N_LSB +: N_W];
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.step_idx  = step_idx;
endmodule

// File: tb/tb_wave_sequencer.sv
// Bench for wave_sequencer: directed scenarios plus random traffic against a behavioural model.
module tb_wave_sequencer;
  localparam int DEPTH = 8;
  localparam int DUR_W = 16;
  localparam int AW    = 3;
  localparam int EW    = 32 + DUR_W;
`ifdef WAVE_SEQ_MUTE_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wave_seq_if #(.DEPTH(DEPTH), .DUR_W(DUR_W)) bus ();
  wave_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: table contents plus "which entry, how many cycles left".
  logic [EW-1:0] tbl [DEPTH];
  bit            active, gap, armed, m_done;
  int            idx, last, left;
  logic [31:0]   cfg;
  int            exp_q[$];

  function automatic logic [EW-1:0] mk(input int dds, input logic [23:0] mid, input int nn, input int dur);
    logic [3:0] d4, n4;
    d4 = dds[3:0];
    n4 = nn[3:0];
    return {DUR_W'(dur), n4, mid, d4};
  endfunction

  function void present(input int i);
    cfg  = tbl[i][31:0];
    left = (tbl[i][EW-1:32] == '0) ? 1 : int'(tbl[i][EW-1:32]);
  endfunction

  function void model_step();
    int ns;
    m_done = 1'b0;
    if (reset) begin
      foreach (tbl[i]) tbl[i] = '0;
      active = 0; gap = 0; idx = 0; cfg = '0; armed = 1;
      return;
    end
    if (active) begin
      if (bus.stop) begin
        active = 0; gap = 0; cfg[3:0] = 4'd0;
      end else if (gap) begin
        gap = 0; present(idx);
      end else if (left > 1) begin
        left--;
      end else if (idx == last && !bus.loop) begin
        active = 0; cfg[3:0] = 4'd0; m_done = 1;
      end else begin
        idx = (idx == last) ? 0 : idx + 1;
        if (GAP_EN) begin
          gap = 1; cfg[3:0] = 4'd0;
        end else begin
          present(idx);
        end
      end
    end else if (bus.start && !bus.stop) begin
      ns     = int'(bus.num_steps);
      last   = (ns == 0) ? 0 : (ns > DEPTH) ? DEPTH - 1 : ns - 1;
      active = 1; idx = 0;
      present(0);
    end
    if (bus.wr_en) tbl[bus.wr_addr] = bus.wr_data;
  endfunction

  function automatic logic [31:0] dut_cfg();
    return {bus.n, bus.mul_3, bus.wave_cs_3, bus.mul_2, bus.wave_cs_2,
            bus.mul_1, bus.wave_cs_1, bus.mul_0, bus.wave_cs_0, bus.dds_cs};
  endfunction

  function automatic int code();
    return (int'(bus.busy) << 9) | (int'(bus.done) << 8) | (int'(bus.step_idx) << 4) | int'(bus.dds_cs);
  endfunction

  task automatic cmp_model();
    logic [AW-1:0] ei;
    ei = idx[AW-1:0];
    if (!armed) return;
    vectors++;
    if (dut_cfg() !== cfg || bus.busy !== active || bus.done !== m_done || bus.step_idx !== ei) begin
      miscompares++;
      $display("FAIL cycle t=%0t: dut cfg=%h busy=%b done=%b idx=%0d, model cfg=%h busy=%b done=%b idx=%0d",
               $time, dut_cfg(), bus.busy, bus.done, bus.step_idx, cfg, active, m_done, ei);
    end
  endtask

  // One clock: model follows the edge, outputs are checked 1 time unit later, return at negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cmp_model();
    @(negedge clk);
  endtask

  task automatic expect_eq(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int a, input logic [EW-1:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a[AW-1:0]; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_trace(input string name, input int poke);
    for (int k = 0; k < exp_q.size(); k++) begin
      expect_eq($sformatf("%s[%0d]", name, k), code(), exp_q[k]);
      if (k == poke) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
  endtask

  task automatic wait_idx(input string name, input int v, input int budget);
    int c = 0;
    while (int'(bus.step_idx) != v && c < budget) begin tick(); c++; end
    expect_eq(name, int'(bus.step_idx), v);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c = 0;
    while (bus.busy && c < budget) begin tick(); c++; end
    expect_eq(name, int'(bus.busy), 0);
  endtask

  task automatic load_abc();
    wr(0, mk(1, 24'h123456, 1, 4));
    wr(1, mk(2, 24'h654321, 2, 2));
    wr(2, mk(3, 24'hABCDEF, 3, 0));
  endtask

  initial begin
    armed = 0;
    reset = 1'b1;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.num_steps = '0; bus.loop = 0; bus.start = 0; bus.stop = 0;
    tick(); tick();
    reset = 1'b0;
    expect_eq("reset_cfg", int'(dut_cfg()), 0);
    expect_eq("reset_code", code(), 0);

    // three-step one-shot
    load_abc();
    bus.num_steps = 4'd3;
    pulse_start();
    if (GAP_EN) exp_q = '{'h201, 'h201, 'h201, 'h201, 'h210, 'h212, 'h212, 'h220, 'h223, 'h120, 'h020};
    else        exp_q = '{'h201, 'h201, 'h201, 'h201, 'h212, 'h212, 'h223, 'h120, 'h020};
    run_trace("oneshot", -1);
    expect_eq("oneshot_n_held", int'(bus.n), 3);

    // looping run, then stop in step 1
    bus.loop = 1'b1;
    pulse_start();
    if (GAP_EN) exp_q = '{'h201, 'h201, 'h201, 'h201, 'h210, 'h212, 'h212, 'h220, 'h223, 'h200, 'h201};
    else        exp_q = '{'h201, 'h201, 'h201, 'h201, 'h212, 'h212, 'h223, 'h201};
    run_trace("loop", -1);
    wait_idx("loop_reach1", 1, 40);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    expect_eq("stop_code", code(), 'h010);
    tick();
    expect_eq("stop_no_done", int'(bus.done), 0);
    bus.loop = 1'b0;

    // start+stop together from IDLE, then a start while busy
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    expect_eq("start_stop_idle", int'(bus.busy), 0);
    pulse_start();
    if (GAP_EN) exp_q = '{'h201, 'h201, 'h201, 'h201, 'h210, 'h212, 'h212, 'h220, 'h223, 'h120, 'h020};
    else        exp_q = '{'h201, 'h201, 'h201, 'h201, 'h212, 'h212, 'h223, 'h120, 'h020};
    run_trace("busy_start", 4);

    // table writes while running
    wr(1, mk(2, 24'h654321, 2, 10));
    pulse_start();
    wait_idx("wr_reach1", 1, 20);
    tick();
    wr(2, mk(3, 24'h000000, 'hA, 1));
    wr(1, mk(5, 24'hFFFFFF, 7, 1));
    expect_eq("live_dds", int'(bus.dds_cs), 2);
    expect_eq("live_n", int'(bus.n), 2);
    wait_idx("wr_reach2", 2, 30);
    if (GAP_EN) tick();
    expect_eq("new_n", int'(bus.n), 'hA);
    wait_idle("wr_idle", 30);

    // reset mid-sequence
    pulse_start();
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_eq("midreset_cfg", int'(dut_cfg()), 0);
    expect_eq("midreset_code", code(), 0);
    pulse_start();
    expect_eq("cleared_busy", int'(bus.busy), 1);
    expect_eq("cleared_cfg", int'(dut_cfg()), 0);
    wait_idle("cleared_idle", 20);

`ifdef WAVE_SEQ_MUTE_GAP_EN
    wr(0, mk(1, 24'h111111, 1, 3));
    wr(1, mk(2, 24'h222222, 2, 3));
    bus.num_steps = 4'd2;
    pulse_start();
    exp_q = '{'h201, 'h201, 'h201, 'h210, 'h212, 'h212, 'h212, 'h110, 'h010};
    run_trace("gap", -1);
`endif

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(0, 499) == 0);
      bus.wr_en     = ($urandom_range(0, 3) == 0);
      bus.wr_addr   = AW'($urandom_range(0, DEPTH - 1));
      bus.wr_data   = {DUR_W'($urandom_range(0, 5)), 32'($urandom)};
      bus.num_steps = 4'($urandom_range(0, 15));
      bus.loop      = ($urandom_range(0, 2) != 0);
      bus.start     = ($urandom_range(0, 7) == 0);
      bus.stop      = ($urandom_range(0, 39) == 0);
      tick();
    end
    reset = 1'b0; bus.wr_en = 0; bus.start = 0; bus.stop = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wave_sequencer.md
WAVE_SEQUENCER -- requirements
Module: wave_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of step-table entries (power of two, 2..16).
REQ-002 Parameter DUR_W, default 16, SHALL set the step-duration field width in clk cycles.
REQ-003 clk  input  1  SHALL be the single clock; all logic rising-edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 wr_en  input  1  SHALL write wr_data into table entry wr_addr on the clk edge.
REQ-006 wr_addr  input  log2(DEPTH)  SHALL select the table entry to write.
REQ-007 wr_data  input  32+DUR_W  SHALL carry the entry: [3:0] dds_cs, [6:4]/[9:7] wave_cs_0/mul_0, [12:10]/[15:13] ch1, [18:16]/[21:19] ch2, [24:22]/[27:25] ch3, [31:28] n, [31+DUR_W:32] duration.
REQ-008 num_steps  input  log2(DEPTH)+1  SHALL give the active step count; it is sampled at start; 0 is treated as 1 and values above DEPTH as DEPTH.
REQ-009 loop  input  1  SHALL, when high, restart at step 0 after the last step; it is sampled at every end of the last step.
REQ-010 start / stop  input  1 each  SHALL be single-cycle command strobes.
REQ-011 dds_cs[3:0], wave_cs_0..3[2:0], mul_0..3[2:0], n[3:0]  output  SHALL be the registered generator configuration.
REQ-012 busy  output  1  SHALL be high while the state is not IDLE.
REQ-013 done  output  1  SHALL pulse for one cycle when a non-looping sequence completes.
REQ-014 step_idx  output  log2(DEPTH)  SHALL show the entry currently presented.

Function
REQ-015 FSM states SHALL be IDLE, RUN and (macro only) GAP.
REQ-016 In IDLE, a start SHALL load entry 0 into the outputs, load the duration counter and enter RUN on the same edge, so outputs change 1 cycle after start.
REQ-017 Each step SHALL present its configuration for exactly D cycles, where D is the entry duration and D=0 is treated as 1.
REQ-018 On the final cycle of step i < num_steps-1, the next edge SHALL present entry i+1 with no idle cycle between steps.
REQ-019 On the final cycle of the last step, the next edge SHALL do one of two things: with loop=1, present entry 0; with loop=0, enter IDLE, drive dds_cs=0, pulse done and hold the other outputs.
REQ-020 A stop SHALL enter IDLE on the next edge with dds_cs=0 and no done pulse.
REQ-021 When start and stop are high together, stop SHALL win.
REQ-022 A start while busy SHALL be ignored.
REQ-023 Table writes SHALL be accepted in any state. A write to an entry not currently presented takes effect when that entry is next loaded. A write to the presented entry does not alter the live outputs or the counter.
REQ-024 step_idx SHALL wrap from num_steps-1 to 0 only via loop.

Reset
REQ-025 Reset SHALL force IDLE and set all outputs to 0: dds_cs, wave_cs_*, mul_*, n, busy, done, step_idx.
REQ-026 Reset SHALL clear all table entries to 0.
REQ-027 Reset asserted mid-sequence SHALL abort on that edge and override start, stop and wr_en.

Configuration
REQ-028 With WAVE_SEQ_MUTE_GAP_EN defined, every step-to-step transition SHALL insert one GAP cycle. During GAP, dds_cs=0, the other outputs hold, busy stays high and step_idx already shows the next entry. This also applies to the loop transition.
REQ-029 Without WAVE_SEQ_MUTE_GAP_EN, the GAP state SHALL not exist and transitions SHALL be seamless per REQ-018.

Structure
REQ-030 Package wave_seq_pkg SHALL hold the entry field offsets and widths, the state enum, and DEPTH/DUR_W defaults.
REQ-031 Sub-module wave_seq_table SHALL implement the table as one synchronous write port and one combinational read port; the FSM, counter and output registers stay in wave_sequencer.

Verification
REQ-032 Write 3 entries (durations 4, 2, 0), num_steps=3, loop=0, start -> entry0 for 4 cycles, entry1 for 2, entry2 for 1; then done pulses for 1 cycle with dds_cs=0 and busy low.
REQ-033 Same table with loop=1 -> after entry2, entry0 reappears on the next edge and step_idx goes 2->0; stop in step 1 -> IDLE next edge, dds_cs=0, no done.
REQ-034 start and stop in the same cycle from IDLE -> stays IDLE; start while busy at step 1 -> sequence unaffected.
REQ-035 During entry1 (duration 10), write entry2 n=4'hA -> when entry2 is presented, n=4'hA; rewrite entry1 -> live outputs unchanged.
REQ-036 Reset asserted on cycle 3 of a running sequence -> next edge all outputs 0, busy 0, and entry 0 reads back 0 on a subsequent start.
REQ-037 With WAVE_SEQ_MUTE_GAP_EN, 2 steps of duration 3 -> 3 cycles entry0, 1 cycle with dds_cs=0, then 3 cycles entry1.
